// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int MAX_WIDTH = 32;
   // Sized for the widest legal WIDTH so every build shares one counter type.
   localparam int CNT_W = $clog2(MAX_WIDTH);

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder used by the serial datapath.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one sum bit per clock through a single full-add cell.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o,
   output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf_o
`endif
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_next;
   logic [WIDTH-1:0] sum_q;
   logic             carry_q, cout_q;
   logic [CNT_W-1:0] cnt_q;
   logic             fa_s, fa_c;
   logic             accept, last_bit;

   fa_cell u_fa (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (carry_q),
      .sum  (fa_s),
      .cout (fa_c)
   );

   assign accept   = in_valid && in_ready;
   assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
   assign sum_next = {fa_s, sum_sh[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      // NOTE: every output gets a default before the case, so no path can infer a latch.
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last_bit) state_d = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Working shift registers are separate from the result register so the
   // previous result stays visible until the next operation completes.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh    <= '0;
         b_sh    <= '0;
         sum_sh  <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
      end else if (accept) begin
         a_sh    <= a_i;
         b_sh    <= b_i;
         carry_q <= cin_i;
         cnt_q   <= '0;
      end else if (state_q == RUN) begin
         a_sh    <= a_sh >> 1;
         b_sh    <= b_sh >> 1;
         sum_sh  <= sum_next;
         carry_q <= fa_c;
         cnt_q   <= cnt_q + CNT_W'(1);
         if (last_bit) begin
            sum_q  <= sum_next;
            cout_q <= fa_c;
         end
      end
   end

   assign sum_o  = sum_q;
   assign cout_o = cout_q;

`ifdef SERIAL_ADDER_OVF_EN
   logic ovf_q;

   // On the MSB step carry_q is the carry into the sign bit.
   always_ff @(posedge clk) begin
      if (rst)                                ovf_q <= 1'b0;
      else if (state_q == RUN && last_bit)    ovf_q <= carry_q ^ fa_c;
   end

   assign ovf_o = ovf_q;
`endif

endmodule
